bsg_then_ready_link_mux_to_bsg_link: RTL
========================================

// Module: bsg_then_ready_link_mux_to_bsg_link
// PURPOSE
//  Multi-channel successor to the single-channel wide<->bsg_link converter. Round-robin arbitrates
//  channels_p wide then_ready links onto one narrow bsg_link as framed packets (header flit + data flits).
//  Deframes the return direction, steering each packet to the wide channel named in its header.
//  Sits at the IO-link edge, so several NoC networks share one physical link.
// PARAMETERS
//  wide_link_width_p  "inv"  payload width of each wide channel
//  bsg_link_width_p   "inv"  narrow link flit width; must be >= id_width_lp
//  channels_p         2      wide channels; 1 = headerless mode (no header flit)
//  derived: ratio_lp = CDIV(wide,bsg); id_width_lp = safe_clog2(channels_p); sif_w = then_ready sif width
// PORTS
//  clk_i        in   1                       clock; sole clock domain
//  reset_n_i    in   1                       asynchronous, active-low reset
//  wide_link_i  in   channels_p*sif_w(wide)  per-channel {v,data,then_ready_rev}; channel c at slice c
//  wide_link_o  out  channels_p*sif_w(wide)  per-channel return direction
//  bsg_link_i   in   sif_w(bsg)              narrow link in
//  bsg_link_o   out  sif_w(bsg)              narrow link out
//  error_o      out  1                       sticky: RX header named an invalid channel
// BEHAVIOUR
//  Handshake: then_ready_rev=1 means the flit is consumed this cycle; only asserted with v, never before.
//  Reset (async on reset_n_i low): every v, then_ready_rev, and error_o is 0; TX and RX FSMs in IDLE;
//   rr_last = channels_p-1, so channel 0 has first priority. Mid-packet reset discards partial frames.
//  Frame: flit0 = header {zeros, id}; flits 1..ratio_lp = wide data, LSB slice first, zero-padded.
//   channels_p==1: no header; frame is ratio_lp flits.
//  TX FSM IDLE/SEND:
//   - Grant: if the FSM is in IDLE, or the last flit is yumi'd this cycle, grant the first valid channel
//     after rr_last.
//   - On grant: assert that channel's then_ready_rev (comb); latch data and id; set rr_last; counter=0;
//     go SEND. No grant -> IDLE.
//   - SEND: bsg_link_o.v=1; data = header at counter 0, else slice counter-1. bsg then_ready_rev
//     increments counter.
//   - Grant-to-header latency is 1 cycle. Back-to-back frames have no bubble: a frame takes ratio_lp+1
//     link cycles.
//   - A non-granted channel's v holds its then_ready_rev at 0. Its data must stay stable per handshake rules.
//  RX FSM HDR/COLLECT/HOLD:
//   - bsg_link_o.then_ready_rev = bsg_link_i.v & (state!=HOLD).
//   - HDR: on accept, latch id; go COLLECT. An invalid id (>=channels_p, or nonzero upper bits) sets drop
//     and error_o.
//   - COLLECT: accepted flits fill slices 0..ratio_lp-1. On the last one, go HOLD (or HDR if drop set;
//     clear drop).
//   - HOLD: wide_link_o[id].v=1 with data truncated to wide width; all other channels' v=0. On that
//     channel's then_ready_rev, go HDR. No new flits are accepted in HOLD.
//   - Latency: first wide v is 1 cycle after the last flit is accepted.
//   - channels_p==1: skip HDR; id is always 0.
//  TX and RX are independent; simultaneous activity on both is allowed. error_o clears only on reset.
// TESTING (wide=32, bsg=8, channels_p=3 unless stated)
//  1 Reset: reset_n_i=0 mid-frame -> all v/rev/error_o = 0 that cycle. Next frame starts from channel 0.
//  2 TX single: ch1 v, data 0xDDCCBBAA, link always ready -> rev pulse on ch1. Link then carries
//    01,AA,BB,CC,DD on 5 consecutive cycles.
//  3 TX contention: all 3 channels valid continuously -> headers 00,01,02,00... with no idle link cycle
//    between frames.
//  4 TX backpressure: link ready dropped for 3 cycles on flit 2 -> flit 2 held stable. Frame completes
//    with order unchanged.
//  5 RX: flits 02,11,22,33,44 -> ch2 v with 0x44332211, held until rev. A 6th flit is not accepted meanwhile.
//  6 RX error: header 03 plus 4 flits -> all consumed, no wide v, error_o=1 sticky. Next valid frame
//    delivered normally.

Source files
------------

// File: rtl/bsg_then_ready_link_mux_to_bsg_link.sv
// Purpose: round-robin mux of wide then_ready channels onto one narrow bsg_link as framed packets; demux on return.
// Latency: TX header flit 1 cycle after grant, back-to-back frames bubble-free; RX wide v 1 cycle after last flit.
// Backpressure: TX flit held until bsg then_ready_rev; RX stops accepting flits while a wide word waits in HOLD.
module bsg_then_ready_link_mux_to_bsg_link #(
    parameter int wide_link_width_p = 32,
    parameter int bsg_link_width_p  = 8,
    parameter int channels_p        = 2
) (
    input  logic                                           clk_i,
    input  logic                                           reset_n_i,
    input  logic [channels_p*(wide_link_width_p+2)-1:0]    wide_link_i,
    output logic [channels_p*(wide_link_width_p+2)-1:0]    wide_link_o,
    input  logic [bsg_link_width_p+1:0]                    bsg_link_i,
    output logic [bsg_link_width_p+1:0]                    bsg_link_o,
    output logic                                           error_o
);

    localparam int ratio_lp    = (wide_link_width_p + bsg_link_width_p - 1) / bsg_link_width_p;
    localparam int id_width_lp = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int wsif_lp     = wide_link_width_p + 2;
    localparam bit hdr_lp      = (channels_p > 1);
    localparam int cnt_w_lp    = $clog2(ratio_lp + 1);
    localparam int pad_w_lp    = ratio_lp * bsg_link_width_p;

    localparam logic [cnt_w_lp-1:0] tx_last_lp = hdr_lp ? cnt_w_lp'(ratio_lp) : cnt_w_lp'(ratio_lp - 1);
    localparam logic [cnt_w_lp-1:0] rx_last_lp = cnt_w_lp'(ratio_lp - 1);

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_HDR,
        RX_COLLECT,
        RX_HOLD
    } rx_state_e;

    // Headerless links have no id flit, so RX lives in COLLECT between frames.
    localparam rx_state_e rx_start_lp = hdr_lp ? RX_HDR : RX_COLLECT;

    // Unpacked link fields
    logic [channels_p-1:0]        in_v;
    logic [channels_p-1:0]        out_rev_in;
    logic [wide_link_width_p-1:0] in_dat [channels_p];
    logic                         b_in_v;
    logic                         b_in_rev;
    logic [bsg_link_width_p-1:0]  b_in_dat;

    always_comb begin
        in_v       = '0;
        out_rev_in = '0;
        for (int c = 0; c < channels_p; c++) begin
            in_v[c]       = wide_link_i[c*wsif_lp + wsif_lp - 1];
            in_dat[c]     = wide_link_i[c*wsif_lp + 1 +: wide_link_width_p];
            out_rev_in[c] = wide_link_i[c*wsif_lp];
        end
    end

    assign b_in_v   = bsg_link_i[bsg_link_width_p+1];
    assign b_in_dat = bsg_link_i[bsg_link_width_p:1];
    assign b_in_rev = bsg_link_i[0];

    // ---------------- TX path ----------------
    tx_state_e                   tx_state_q, tx_state_d;
    logic [cnt_w_lp-1:0]         tx_cnt_q, tx_cnt_d;
    logic [pad_w_lp-1:0]         tx_data_q, tx_data_d;
    logic [id_width_lp-1:0]      tx_id_q, tx_id_d;
    logic [id_width_lp-1:0]      rr_last_q, rr_last_d;

    logic                         grant_found;
    logic [id_width_lp-1:0]       grant_id;
    logic [wide_link_width_p-1:0] grant_dat;
    logic                         tx_yumi;
    logic                         tx_last;
    logic                         tx_grant_en;
    logic [cnt_w_lp-1:0]          tx_slice_idx;
    logic [bsg_link_width_p-1:0]  tx_flit;

    // Search starts just after the last winner, so every channel gets a turn.
    always_comb begin : tx_arb
        int j;
        j           = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= channels_p; k++) begin
            j = (int'(rr_last_q) + k) % channels_p;
            if (!grant_found && in_v[j]) begin
                grant_found = 1'b1;
                grant_id    = id_width_lp'(j);
            end
        end
    end

    always_comb begin
        grant_dat = '0;
        for (int c = 0; c < channels_p; c++) begin
            if (grant_id == id_width_lp'(c)) begin
                grant_dat = in_dat[c];
            end
        end
    end

    assign tx_yumi     = (tx_state_q == TX_SEND) && b_in_rev;
    assign tx_last     = tx_yumi && (tx_cnt_q == tx_last_lp);
    assign tx_grant_en = (tx_state_q == TX_IDLE) || tx_last;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_data_d  = tx_data_q;
        tx_id_d    = tx_id_q;
        rr_last_d  = rr_last_q;
        if (tx_yumi) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
        if (tx_grant_en) begin
            if (grant_found) begin
                tx_state_d                      = TX_SEND;
                tx_cnt_d                        = '0;
                tx_data_d                       = '0;
                tx_data_d[wide_link_width_p-1:0] = grant_dat;
                tx_id_d                         = grant_id;
                rr_last_d                       = grant_id;
            end else begin
                tx_state_d = TX_IDLE;
            end
        end
    end

    always_comb begin
        tx_flit      = '0;
        tx_slice_idx = hdr_lp ? (tx_cnt_q - 1'b1) : tx_cnt_q;
        if (hdr_lp && (tx_cnt_q == '0)) begin
            tx_flit[id_width_lp-1:0] = tx_id_q;
        end else begin
            for (int i = 0; i < ratio_lp; i++) begin
                if (tx_slice_idx == cnt_w_lp'(i)) begin
                    tx_flit = tx_data_q[i*bsg_link_width_p +: bsg_link_width_p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_data_q  <= '0;
            tx_id_q    <= '0;
            rr_last_q  <= id_width_lp'(channels_p - 1);
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_id_q    <= tx_id_d;
            rr_last_q  <= rr_last_d;
        end
    end

    // ---------------- RX path ----------------
    rx_state_e              rx_state_q, rx_state_d;
    logic [cnt_w_lp-1:0]    rx_cnt_q, rx_cnt_d;
    logic [pad_w_lp-1:0]    rx_buf_q, rx_buf_d;
    logic [id_width_lp-1:0] rx_id_q, rx_id_d;
    logic                   rx_drop_q, rx_drop_d;
    logic                   error_q, error_d;

    logic rx_accept;
    logic rx_rev_sel;

    assign rx_accept = b_in_v && (rx_state_q != RX_HOLD);

    always_comb begin
        rx_rev_sel = 1'b0;
        for (int c = 0; c < channels_p; c++) begin
            if (rx_id_q == id_width_lp'(c)) begin
                rx_rev_sel = out_rev_in[c];
            end
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_buf_d   = rx_buf_q;
        rx_id_d    = rx_id_q;
        rx_drop_d  = rx_drop_q;
        error_d    = error_q;
        case (rx_state_q)
            RX_HDR: begin
                if (rx_accept) begin
                    rx_id_d    = b_in_dat[id_width_lp-1:0];
                    rx_cnt_d   = '0;
                    rx_state_d = RX_COLLECT;
                    // Covers both out-of-range ids and stray upper header bits.
                    if (b_in_dat >= bsg_link_width_p'(channels_p)) begin
                        rx_drop_d = 1'b1;
                        error_d   = 1'b1;
                    end
                end
            end
            RX_COLLECT: begin
                if (rx_accept) begin
                    for (int i = 0; i < ratio_lp; i++) begin
                        if (rx_cnt_q == cnt_w_lp'(i)) begin
                            rx_buf_d[i*bsg_link_width_p +: bsg_link_width_p] = b_in_dat;
                        end
                    end
                    rx_cnt_d = rx_cnt_q + 1'b1;
                    if (rx_cnt_q == rx_last_lp) begin
                        rx_cnt_d   = '0;
                        rx_drop_d  = 1'b0;
                        rx_state_d = rx_drop_q ? rx_start_lp : RX_HOLD;
                    end
                end
            end
            RX_HOLD: begin
                if (rx_rev_sel) begin
                    rx_state_d = rx_start_lp;
                end
            end
            default: begin
                rx_state_d = rx_start_lp;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state_q <= rx_start_lp;
            rx_cnt_q   <= '0;
            rx_buf_q   <= '0;
            rx_id_q    <= '0;
            rx_drop_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_buf_q   <= rx_buf_d;
            rx_id_q    <= rx_id_d;
            rx_drop_q  <= rx_drop_d;
            error_q    <= error_d;
        end
    end

    // ---------------- Output packing ----------------
    // Handshake outputs are gated by reset so nothing is offered or consumed while it is held.
    always_comb begin
        wide_link_o = '0;
        for (int c = 0; c < channels_p; c++) begin
            wide_link_o[c*wsif_lp + wsif_lp - 1] = reset_n_i && (rx_state_q == RX_HOLD)
                                                   && (rx_id_q == id_width_lp'(c));
            wide_link_o[c*wsif_lp + 1 +: wide_link_width_p] = rx_buf_q[wide_link_width_p-1:0];
            wide_link_o[c*wsif_lp] = reset_n_i && tx_grant_en && grant_found
                                     && (grant_id == id_width_lp'(c));
        end
    end

    assign bsg_link_o = {reset_n_i && (tx_state_q == TX_SEND), tx_flit, reset_n_i && rx_accept};
    assign error_o    = error_q;

endmodule
